// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner / digit-entry block.
package keypad_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned CODE_W     = 4;
   localparam int unsigned ROWS       = 4;
   localparam int unsigned COLS       = 4;
   localparam int unsigned NKEYS      = ROWS * COLS;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned DIGITS_W   = 4;
   localparam int unsigned MAX_DIGITS = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS   = 2'd1,
      HELD    = 2'd2,
      RELEASE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      SINGLE = 2'd1,
      MULTI  = 2'd2
   } frame_res_e;

   typedef struct packed {
      frame_res_e             res;
      logic [CODE_W-1:0]      code;
   } frame_t;

   // Classify one frame of pressed keys; bit index equals key code {row, col}.
   function automatic frame_t frame_eval(input logic [NKEYS-1:0] pressed);
      frame_t      f;
      int unsigned n;
      f.res  = NONE;
      f.code = '0;
      n      = 0;
      for (int unsigned i = 0; i < NKEYS; i++) begin
         if (pressed[i]) begin
            if (n == 0) f.code = CODE_W'(i);
            n++;
         end
      end
      if (n == 1)      f.res = SINGLE;
      else if (n >= 2) f.res = MULTI;
      return f;
   endfunction

endpackage

// File: rtl/key_sync.sv
// Parameterizable-width 2-flop synchronizer with async active-low reset.
module key_sync #(
   parameter int unsigned   W       = 1,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         q      <= RST_VAL;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 hex keypad scanner with frame-level debounce and an 8-nibble entry word.
// Optional column synchronizer: define KEYPAD_COL_SYNC_EN.
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 32768,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [COLS-1:0]      col,
   output logic [ROWS-1:0]      row,
   input  logic                 clear,
   output logic [DATA_W-1:0]    data,
   output logic [DIGITS_W-1:0]  digits,
   output logic                 key_valid,
   output logic [CODE_W-1:0]    key_code
);

   localparam int unsigned      DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEB      = CNT_W'(DEBOUNCE);

   logic [COLS-1:0] col_s;

`ifdef KEYPAD_COL_SYNC_EN
   key_sync #(
      .W       (COLS),
      .RST_VAL ({COLS{1'b1}})
   ) u_col_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (col),
      .q     (col_s)
   );
`else
   assign col_s = col;
`endif

   // Row scan: divider, row index, row drive and per-row column capture.
   logic [DIV_W-1:0]        div_q;
   logic [1:0]              row_idx_q;
   logic [3*COLS-1:0]       rows_q;
   logic                    dwell_end_c;
   logic                    frame_end_c;
   logic [NKEYS-1:0]        pressed_c;
   frame_t                  frame_c;

   assign dwell_end_c = (div_q == DIV_LAST);
   assign frame_end_c = dwell_end_c && (row_idx_q == 2'd3);
   assign pressed_c   = {~col_s, rows_q};
   assign frame_c     = frame_eval(pressed_c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q     <= '0;
         row_idx_q <= 2'd0;
         row       <= 4'b1110;
         rows_q    <= '0;
      end else if (dwell_end_c) begin
         div_q     <= '0;
         row_idx_q <= row_idx_q + 2'd1;
         row       <= ~(4'b0001 << 2'(row_idx_q + 2'd1));
         case (row_idx_q)
            2'd0:    rows_q[3:0]  <= ~col_s;
            2'd1:    rows_q[7:4]  <= ~col_s;
            2'd2:    rows_q[11:8] <= ~col_s;
            default: rows_q       <= rows_q;
         endcase
      end else begin
         div_q <= div_q + DIV_W'(1);
      end
   end

   // Debounce FSM, advanced only on frame end.
   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CODE_W-1:0]   cand_q, cand_d;
   logic                accept_c;
   logic [CODE_W-1:0]   acc_code_c;
   logic [CNT_W-1:0]    cnt_inc_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cand_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cand_d     = cand_q;
      accept_c   = 1'b0;
      acc_code_c = cand_q;
      cnt_inc_c  = cnt_q + CNT_W'(1);
      if (frame_end_c) begin
         case (state_q)
            IDLE: begin
               if (frame_c.res == SINGLE) begin
                  cand_d     = frame_c.code;
                  acc_code_c = frame_c.code;
                  if (DEBOUNCE <= 1) begin
                     accept_c = 1'b1;
                     state_d  = HELD;
                     cnt_d    = '0;
                  end else begin
                     state_d  = PRESS;
                     cnt_d    = CNT_W'(1);
                  end
               end
            end
            PRESS: begin
               if ((frame_c.res == SINGLE) && (frame_c.code == cand_q)) begin
                  if (cnt_inc_c >= DEB) begin
                     accept_c = 1'b1;
                     state_d  = HELD;
                     cnt_d    = '0;
                  end else begin
                     cnt_d    = cnt_inc_c;
                  end
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            HELD: begin
               // No auto-repeat: only a clean NONE frame starts the release count.
               if (frame_c.res == NONE) begin
                  if (DEBOUNCE <= 1) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     state_d = RELEASE;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            RELEASE: begin
               if (frame_c.res == NONE) begin
                  if (cnt_inc_c >= DEB) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d   = cnt_inc_c;
                  end
               end else begin
                  state_d = HELD;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Entry register; clear takes priority over a coincident accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data      <= '0;
         digits    <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
      end else begin
         key_valid <= accept_c;
         if (accept_c) key_code <= acc_code_c;
         if (clear) begin
            data   <= '0;
            digits <= '0;
         end else if (accept_c) begin
            data <= {data[DATA_W-CODE_W-1:0], acc_code_c};
            if (digits < DIGITS_W'(MAX_DIGITS)) digits <= digits + DIGITS_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a row-driven keypad model (SCAN_DIV=4, DEBOUNCE=2).
module tb_keypad_entry;

   localparam int unsigned FRAME = 16;

   logic        clk;
   logic        rst_n;
   logic [3:0]  col;
   logic [3:0]  row;
   logic        clear;
   logic [31:0] data;
   logic [3:0]  digits;
   logic        key_valid;
   logic [3:0]  key_code;

   logic [15:0] keys;
   int          pulses;
   int          n_vec;
   int          n_err;

   keypad_entry #(
      .SCAN_DIV (4),
      .DEBOUNCE (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .col       (col),
      .row       (row),
      .clear     (clear),
      .data      (data),
      .digits    (digits),
      .key_valid (key_valid),
      .key_code  (key_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad: a pressed key pulls its column low while its row is driven.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         if (!row[r]) col = col & ~keys[r*4 +: 4];
   end

   always @(negedge clk) if (key_valid === 1'b1) pulses++;

   typedef struct {
      logic [15:0] keys;
      int unsigned frames;
      logic        clr;
      logic [31:0] exp_data;
      logic [3:0]  exp_digits;
      int          exp_pulses;
      logic [3:0]  exp_code;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_frames(input int unsigned n);
      repeat (n * FRAME) @(negedge clk);
   endtask

   task automatic add(input logic [15:0] k, input int unsigned f, input logic c,
                      input logic [31:0] d, input logic [3:0] g, input int p, input logic [3:0] kc);
      vec_t v;
      v.keys = k; v.frames = f; v.clr = c;
      v.exp_data = d; v.exp_digits = g; v.exp_pulses = p; v.exp_code = kc;
      vecs.push_back(v);
   endtask

   initial begin
      logic [3:0]  er;
      logic [31:0] d;
      logic [3:0]  g;
      int          p0;

      // Table: expected values worked out by hand for DEBOUNCE=2.
      add(16'h0040, 6, 1'b0, 32'h0000_0006, 4'd1, 1, 4'h6);
      add(16'h0000, 2, 1'b0, 32'h0000_0006, 4'd1, 0, 4'h6);
      d = 32'h0000_0006;
      g = 4'd1;
      for (int i = 1; i <= 9; i++) begin
         d = {d[27:0], 4'(i)};
         g = (g < 4'd8) ? g + 4'd1 : g;
         add(16'(1 << i), 2, 1'b0, d, g, 1, 4'(i));
         add(16'h0000,    2, 1'b0, d, g, 0, 4'(i));
      end
      add(16'h1000, 1, 1'b0, 32'h2345_6789, 4'd8, 0, 4'h9);
      add(16'h0000, 1, 1'b0, 32'h2345_6789, 4'd8, 0, 4'h9);
      add(16'h0028, 4, 1'b0, 32'h2345_6789, 4'd8, 0, 4'h9);
      add(16'h0008, 2, 1'b0, 32'h3456_7893, 4'd8, 1, 4'h3);
      add(16'h0000, 2, 1'b0, 32'h3456_7893, 4'd8, 0, 4'h3);
      add(16'h0020, 2, 1'b0, 32'h4567_8935, 4'd8, 1, 4'h5);
      add(16'h0000, 1, 1'b0, 32'h4567_8935, 4'd8, 0, 4'h5);
      add(16'h0020, 1, 1'b0, 32'h4567_8935, 4'd8, 0, 4'h5);
      add(16'h0000, 2, 1'b0, 32'h4567_8935, 4'd8, 0, 4'h5);
      add(16'h0000, 1, 1'b1, 32'h0000_0000, 4'd0, 0, 4'h5);
      add(16'h0080, 2, 1'b0, 32'h0000_0007, 4'd1, 1, 4'h7);
      add(16'h0000, 2, 1'b0, 32'h0000_0007, 4'd1, 0, 4'h7);

      n_vec  = 0;
      n_err  = 0;
      pulses = 0;
      rst_n  = 1'b0;
      clear  = 1'b0;
      keys   = 16'h0040;

      // Reset values, then the row walk with a key already held.
      repeat (3) @(negedge clk);
      #1;
      check("rst_row",       32'(row),       32'h0000_000E);
      check("rst_data",      data,           32'h0);
      check("rst_digits",    32'(digits),    32'h0);
      check("rst_key_valid", 32'(key_valid), 32'h0);
      check("rst_key_code",  32'(key_code),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         #1;
         er = ~(4'b0001 << ((k / 4) % 4));
         check($sformatf("row_walk_%0d", k), 32'(row), 32'(er));
      end

      // Reset mid-debounce (one frame already seen) discards the candidate.
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_row",       32'(row),       32'h0000_000E);
      check("midrst_data",      data,           32'h0);
      check("midrst_digits",    32'(digits),    32'h0);
      check("midrst_key_valid", 32'(key_valid), 32'h0);
      keys = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      p0 = pulses;
      run_frames(4);
      #1;
      check("midrst_no_pulse", 32'(pulses - p0), 32'h0);
      check("midrst_data2",    data,              32'h0);
      check("midrst_digits2",  32'(digits),       32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         p0   = pulses;
         keys = vecs[i].keys;
         if (vecs[i].clr) begin
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            repeat (vecs[i].frames * FRAME - 1) @(negedge clk);
         end else begin
            run_frames(vecs[i].frames);
         end
         #1;
         check($sformatf("v%0d_data", i),   data,              vecs[i].exp_data);
         check($sformatf("v%0d_digits", i), 32'(digits),       32'(vecs[i].exp_digits));
         check($sformatf("v%0d_pulses", i), 32'(pulses - p0),  32'(vecs[i].exp_pulses));
         check($sformatf("v%0d_code", i),   32'(key_code),     32'(vecs[i].exp_code));
      end

      // Clear on the accept edge of key 0xA.
      p0   = pulses;
      keys = 16'h0400;
      run_frames(1);
      repeat (FRAME - 1) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      #1;
      check("clracc_key_valid", 32'(key_valid),   32'h1);
      check("clracc_key_code",  32'(key_code),    32'h0000_000A);
      check("clracc_data",      data,             32'h0);
      check("clracc_digits",    32'(digits),      32'h0);
      check("clracc_pulses",    32'(pulses - p0), 32'h1);
      keys = 16'h0000;
      run_frames(2);
      keys = 16'h8000;
      run_frames(2);
      #1;
      check("after_clr_data",   data,           32'h0000_000F);
      check("after_clr_digits", 32'(digits),    32'h1);
      check("after_clr_code",   32'(key_code),  32'h0000_000F);
      keys = 16'h0000;
      run_frames(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
